multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 64, meaning datapath width (documentation only; no port depends on it).
REQ-002 SHALL have port clk input 1: sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port inst input 32: instruction word from instruction_MEM; opcode is inst[31:26].
REQ-005 SHALL have port zero input 1: ALU zero flag.
REQ-006 SHALL have port imem_ready input 1: instruction fetch complete this cycle.
REQ-007 SHALL have port dmem_ready input 1: data access complete this cycle.
REQ-008 SHALL have outputs RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, PCen, PCSrc, Jump, IRWrite, imem_req, illegal, each 1 bit.
REQ-009 SHALL have output ALUOp 2 bits: 00 add, 01 subtract, 10 decode funct.
REQ-010 SHALL have output state 3 bits: current FSM state code.

Function
REQ-011 SHALL implement Moore FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH next cycle with all outputs 0.
REQ-012 SHALL latch opcode into an internal register on the FETCH->DECODE edge; all later decisions SHALL use the latched opcode, not live inst.
REQ-013 FETCH SHALL assert imem_req; on imem_ready=1, assert IRWrite=1 and PCen=1 (PC<=PC+4) that cycle and go DECODE; otherwise hold FETCH with IRWrite=PCen=0.
REQ-014 DECODE SHALL last exactly 1 cycle, all control outputs 0; legal opcode goes EXEC.
REQ-015 Legal opcodes SHALL be R-type 000000, DADDI 011000, LD 110111, SD 111111, BEQ 000100, J 000010.
REQ-016 Illegal opcode in DECODE SHALL pulse illegal=1 for that cycle and return to FETCH; no register, memory or PC write.
REQ-017 EXEC, R-type: ALUSrc=0, ALUOp=10, go WB.
REQ-018 EXEC, DADDI/LD/SD: ALUSrc=1, ALUOp=00; DADDI goes WB, LD/SD go MEM.
REQ-019 EXEC, BEQ: ALUSrc=0, ALUOp=01, PCSrc=1, PCen=zero (sampled same cycle), go FETCH.
REQ-020 EXEC, J: Jump=1, PCen=1, go FETCH.
REQ-021 MEM, LD: MemRead=1 held until dmem_ready=1, then go WB.
REQ-022 MEM, SD: MemWrite=1 held until dmem_ready=1, then go FETCH; MemWrite SHALL never be asserted in any other state.
REQ-023 WB SHALL assert RegWrite=1 for exactly 1 cycle: R-type RegDst=1, MemToReg=0; DADDI RegDst=0, MemToReg=0; LD RegDst=0, MemToReg=1; then go FETCH.
REQ-024 Instruction latency (no wait states): R/DADDI 4 cycles, LD 5, SD 4, BEQ/J 3, illegal 2.
REQ-025 Each ready wait cycle SHALL add exactly 1 cycle; ready asserted outside its waiting state SHALL be ignored.
REQ-026 Unused outputs in each state SHALL be 0; no output SHALL glitch between states (registered state, combinational decode of state and latched opcode only).

Reset
REQ-027 rst_n=0 SHALL immediately force state=FETCH, latched opcode=0, and all outputs 0 except imem_req, which follows FETCH decode after reset releases.
REQ-028 Reset mid-instruction (incl. during MEM wait) SHALL abort it with no further RegWrite/MemWrite/PCen; first cycle after release is FETCH.

Verification
REQ-029 R-type add, ready always 1 -> states 0,1,2,4,0; RegWrite=1 only in cycle 4 with RegDst=1, ALUOp=10 in EXEC.
REQ-030 LD with dmem_ready low 3 cycles -> MEM held 4 cycles with MemRead=1, then WB with MemToReg=1, total latency 8.
REQ-031 BEQ with zero=1 then with zero=0 -> PCen=1/PCSrc=1 in EXEC for first, PCen=0 for second; both return to FETCH after 3 cycles.
REQ-032 Opcode 111000 -> illegal=1 in DECODE cycle only, next state FETCH, RegWrite/MemWrite/PCen never 1.
REQ-033 rst_n pulled low during SD MEM wait -> MemWrite drops asynchronously, state=0; after release fetch resumes, no WB.
REQ-034 imem_ready low 5 cycles in FETCH -> imem_req held, IRWrite/PCen 0 until ready, then single IRWrite/PCen pulse.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: a Moore FSM that steps each instruction
// through FETCH, DECODE, EXEC, MEM and WB. It issues the datapath control
// strobes for each step.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   inst           instruction word; the opcode inst[31:26] is latched on fetch
//   zero           ALU zero flag, used by BEQ in EXEC
//   imem_ready     instruction fetch completes this cycle
//   dmem_ready     data access completes this cycle
//   RegDst .. illegal  one-bit datapath strobes, all zero unless the state needs them
//   ALUOp          00 add, 01 subtract, 10 decode funct
//   state          current FSM state code
module multicycle_ctrl #(
  parameter int unsigned SIZE = 64  // datapath width, informational only
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        PCen,
  output logic        PCSrc,
  output logic        Jump,
  output logic        IRWrite,
  output logic        imem_req,
  output logic        illegal,
  output logic [1:0]  ALUOp,
  output logic [2:0]  state
);

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpDaddi = 6'b011000;
  localparam logic [5:0] OpLd    = 6'b110111;
  localparam logic [5:0] OpSd    = 6'b111111;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] opcode_q;
  logic       opcode_legal;
  logic       fetch_done;

  // Operand fields and the width parameter are not used by the control path.
  logic unused_bits;
  assign unused_bits = ^{inst[25:0], SIZE};

  assign state = state_q;

  always_comb begin
    unique case (opcode_q)
      OpRType, OpDaddi, OpLd, OpSd, OpBeq, OpJ: opcode_legal = 1'b1;
      default:                                  opcode_legal = 1'b0;
    endcase
  end

  // Qualified with rst_n so that IRWrite/PCen stay low while reset is held,
  // even though the reset state is FETCH.
  assign fetch_done = imem_ready & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      opcode_q <= 6'b000000;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch && imem_ready) begin
        opcode_q <= inst[31:26];
      end
    end
  end

  always_comb begin
    state_d  = StFetch;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    PCen     = 1'b0;
    PCSrc    = 1'b0;
    Jump     = 1'b0;
    IRWrite  = 1'b0;
    imem_req = 1'b0;
    illegal  = 1'b0;
    ALUOp    = AluAdd;

    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (fetch_done) begin
          IRWrite = 1'b1;
          PCen    = 1'b1;
          state_d = StDecode;
        end else begin
          state_d = StFetch;
        end
      end

      StDecode: begin
        if (opcode_legal) begin
          state_d = StExec;
        end else begin
          illegal = 1'b1;
          state_d = StFetch;
        end
      end

      StExec: begin
        case (opcode_q)
          OpRType: begin
            ALUOp   = AluFunct;
            state_d = StWb;
          end
          OpDaddi: begin
            ALUSrc  = 1'b1;
            state_d = StWb;
          end
          OpLd, OpSd: begin
            ALUSrc  = 1'b1;
            state_d = StMem;
          end
          OpBeq: begin
            ALUOp = AluSub;
            PCSrc = 1'b1;
            PCen  = zero;
          end
          OpJ: begin
            Jump = 1'b1;
            PCen = 1'b1;
          end
          default: state_d = StFetch;
        endcase
      end

      StMem: begin
        if (opcode_q == OpLd) begin
          MemRead = 1'b1;
          state_d = dmem_ready ? StWb : StMem;
        end else if (opcode_q == OpSd) begin
          MemWrite = 1'b1;
          state_d  = dmem_ready ? StFetch : StMem;
        end
      end

      StWb: begin
        RegWrite = 1'b1;
        RegDst   = (opcode_q == OpRType);
        MemToReg = (opcode_q == OpLd);
      end

      default: state_d = StFetch;
    endcase
  end

endmodule
